// File: rtl/pmp_pkg.sv
// pmp_pkg: shared state encoding and default sizing for the PMP pattern matcher.
package pmp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int MAX_PAT_DEF = 8;
  localparam int CHAR_W_DEF = 8;
endpackage

// File: rtl/pmp_window_cmp.sv
// pmp_window_cmp: sliding window of recent text chars compared against the pattern.
// hit reflects the window as it will look after the current char shifts in.
module pmp_window_cmp
  import pmp_pkg::*;
#(
  parameter int MAX_PAT = MAX_PAT_DEF,
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int LEN_W = $clog2(MAX_PAT + 1),
  parameter int IDX_W = $clog2(MAX_PAT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             shift,
  input  logic [CHAR_W-1:0]                din,
  input  logic [MAX_PAT-1:0][CHAR_W-1:0]   pattern,
  input  logic [LEN_W-1:0]                 pat_len,
  output logic                             hit
);
  logic [MAX_PAT-1:0][CHAR_W-1:0] win, nxt;
  assign nxt = {win[MAX_PAT-2:0], din};
  always_ff @(posedge clk) begin
    if (reset || clr) win <= '0;
    else if (shift) win <= nxt;
  end
  // pattern char k lines up with the window slot pat_len-1-k (oldest char first)
  always_comb begin
    hit = 1'b1;
    for (int k = 0; k < MAX_PAT; k++)
      if (LEN_W'(k) < pat_len && nxt[IDX_W'(pat_len - LEN_W'(k) - LEN_W'(1))] != pattern[k]) hit = 1'b0;
  end
endmodule

// File: rtl/pmp_match_core.sv
// pmp_match_core: streaming pattern matcher counting overlapping occurrences in a text.
module pmp_match_core
  import pmp_pkg::*;
#(
  parameter int MAX_PAT = MAX_PAT_DEF,
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_PAT+1)-1:0]   pat_len,
  input  logic                           pat_we,
  input  logic [$clog2(MAX_PAT)-1:0]     pat_idx,
  input  logic [CHAR_W-1:0]              pat_data,
  input  logic                           txt_valid,
  output logic                           txt_ready,
  input  logic [CHAR_W-1:0]              txt_data,
  input  logic                           txt_last,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           found,
  output logic                           match_pulse,
  output logic [CNT_W-1:0]               match_count,
  output logic [CNT_W-1:0]               first_pos
);
  localparam int LEN_W = $clog2(MAX_PAT + 1);
  localparam int IDX_W = $clog2(MAX_PAT);
  state_t state, state_nxt;
  logic [MAX_PAT-1:0][CHAR_W-1:0] pattern;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] pos;
  logic [CNT_W:0] seen;
  logic accept, legal, hit, match;
  assign legal = pat_len != '0 && pat_len <= LEN_W'(MAX_PAT);
  assign txt_ready = state == SCAN;
  assign busy = state == SCAN;
  assign done = state == DONE;
  assign accept = txt_valid && txt_ready;
  // one extra bit so a saturated pos still admits matches
  assign seen = {1'b0, pos} + (CNT_W+1)'(1);
  assign match = accept && hit && seen >= (CNT_W+1)'(len_q);
  always_comb
    state_nxt = start ? (legal ? SCAN : DONE) : (state == SCAN && accept && txt_last) ? DONE : state;
  pmp_window_cmp #(.MAX_PAT(MAX_PAT), .CHAR_W(CHAR_W), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_win (
    .clk(clk),
    .reset(reset),
    .clr(start),
    .shift(accept),
    .din(txt_data),
    .pattern(pattern),
    .pat_len(len_q),
    .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pattern <= '0;
      len_q <= '0;
      pos <= '0;
      match_count <= '0;
      first_pos <= '0;
      found <= 1'b0;
      match_pulse <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pat_we && state != SCAN) pattern[pat_idx] <= pat_data;
      match_pulse <= !start && match;
      if (start) begin
        len_q <= pat_len;
        pos <= '0;
        match_count <= '0;
        first_pos <= '0;
        found <= 1'b0;
        err <= !legal;
      end else if (accept) begin
        pos <= &pos ? pos : pos + CNT_W'(1);
        if (match) begin
          match_count <= &match_count ? match_count : match_count + CNT_W'(1);
          found <= 1'b1;
          if (!found) first_pos <= pos - CNT_W'(len_q) + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pmp_match_core.sv
// tb_pmp_match_core: directed vectors with hand-computed results for pmp_match_core.
module tb_pmp_match_core;
  logic clk = 1'b0;
  logic reset, start, pat_we, txt_valid, txt_last;
  logic [3:0] pat_len;
  logic [2:0] pat_idx;
  logic [7:0] pat_data, txt_data;
  logic txt_ready, busy, done, err, found, match_pulse;
  logic [15:0] match_count, first_pos;
  int n_chk = 0;
  int n_fail = 0;
  int pulses;
  always #5 clk = ~clk;
  pmp_match_core #(.MAX_PAT(8), .CHAR_W(8), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pat_len(pat_len),
    .pat_we(pat_we),
    .pat_idx(pat_idx),
    .pat_data(pat_data),
    .txt_valid(txt_valid),
    .txt_ready(txt_ready),
    .txt_data(txt_data),
    .txt_last(txt_last),
    .busy(busy),
    .done(done),
    .err(err),
    .found(found),
    .match_pulse(match_pulse),
    .match_count(match_count),
    .first_pos(first_pos)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      pat_we = 1'b1;
      pat_idx = 3'(i);
      pat_data = s[i];
      tick();
    end
    pat_we = 1'b0;
  endtask
  task automatic do_start(input logic [3:0] len);
    start = 1'b1;
    pat_len = len;
    tick();
    start = 1'b0;
  endtask
  task automatic stream(input string s, input bit last_on, input bit gap);
    pulses = 0;
    for (int i = 0; i < s.len(); i++) begin
      txt_valid = 1'b1;
      txt_data = s[i];
      txt_last = last_on && i == s.len() - 1;
      tick();
      pulses += int'(match_pulse);
      if (gap) begin
        txt_valid = 1'b0;
        txt_last = 1'b0;
        tick();
        pulses += int'(match_pulse);
      end
    end
    txt_valid = 1'b0;
    txt_last = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; pat_we = 1'b0; txt_valid = 1'b0; txt_last = 1'b0;
    pat_len = '0; pat_idx = '0; pat_data = '0; txt_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", txt_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_found", found, 0);
    chk("rst_count", match_count, 0);
    chk("rst_first", first_pos, 0);
    txt_valid = 1'b1; txt_data = "a";
    tick();
    txt_valid = 1'b0;
    chk("idle_valid_ignored", busy, 0);
    // 1: "abc" in "xabcabc"
    load("abc");
    do_start(4'd3);
    chk("t1_busy", busy, 1);
    stream("xabcabc", 1, 0);
    chk("t1_count", match_count, 2);
    chk("t1_first", first_pos, 1);
    chk("t1_pulses", pulses, 2);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_found", found, 1);
    // 2: overlapping "aa" in "aaaa"
    load("aa");
    do_start(4'd2);
    stream("aaaa", 1, 0);
    chk("t2_count", match_count, 3);
    chk("t2_first", first_pos, 0);
    chk("t2_pulses", pulses, 3);
    // 3: illegal lengths
    do_start(4'd0);
    chk("t3a_done", done, 1);
    chk("t3a_err", err, 1);
    chk("t3a_count", match_count, 0);
    chk("t3a_ready", txt_ready, 0);
    do_start(4'd9);
    chk("t3b_done", done, 1);
    chk("t3b_err", err, 1);
    chk("t3b_ready", txt_ready, 0);
    // 4: restart mid-scan clears window and counters
    load("ab");
    do_start(4'd2);
    chk("t4_err_clr", err, 0);
    stream("ab", 0, 0);
    chk("t4_pre_count", match_count, 1);
    do_start(4'd2);
    chk("t4_restart_count", match_count, 0);
    chk("t4_restart_found", found, 0);
    chk("t4_restart_busy", busy, 1);
    stream("b", 1, 0);
    chk("t4_count", match_count, 0);
    chk("t4_found", found, 0);
    chk("t4_done", done, 1);
    // 5: gapped valid, pattern write during scan ignored
    load("q");
    do_start(4'd1);
    pat_we = 1'b1; pat_idx = 3'd0; pat_data = "z";
    tick();
    pat_we = 1'b0;
    stream("zzq", 1, 1);
    chk("t5_count", match_count, 1);
    chk("t5_first", first_pos, 2);
    chk("t5_pulses", pulses, 1);
    // 6: reset mid-scan, then a fresh scan
    do_start(4'd1);
    stream("q", 0, 0);
    chk("t6_pre_count", match_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_found", found, 0);
    chk("t6_count", match_count, 0);
    chk("t6_ready", txt_ready, 0);
    load("ab");
    do_start(4'd2);
    stream("xab", 1, 0);
    chk("t6_re_count", match_count, 1);
    chk("t6_re_first", first_pos, 1);
    chk("t6_re_done", done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
